// File: rtl/raw_bayer_pkg.sv
// Shared types and the Bayer channel picker for the RGB-to-RAW re-mosaic path.
// The mosaic order names the colour of the pixel at row 0, column 0.
package raw_bayer_pkg;

  typedef enum logic [1:0] {
    S_VBLANK = 2'd0,
    S_LINE   = 2'd1,
    S_HBLANK = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    BAYER_RGGB = 2'd0,
    BAYER_GRBG = 2'd1,
    BAYER_GBRG = 2'd2,
    BAYER_BGGR = 2'd3
  } bayer_order_t;

  // Selects the mosaic channel for a pixel position and widens it to 10 bits by MSB replication.
  function automatic logic [9:0] bayer_pick(input bayer_order_t order, input logic x0, input logic y0,
                                            input logic [7:0] r, input logic [7:0] g,
                                            input logic [7:0] b);
    logic [1:0] p;
    logic [7:0] c;
    p = {y0 ^ order[1], x0 ^ order[0]};
    case (p)
      2'b00:   c = r;
      2'b11:   c = b;
      default: c = g;
    endcase
    return {c, c[7:6]};
  endfunction

endpackage

// File: rtl/sensor_timing_gen.sv
// Sensor-style frame/line sequencer: vertical blank, active line, horizontal blank.
// Exposes the current state and the column/row of the pixel slot being produced.
module sensor_timing_gen
  import raw_bayer_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_BLANK  = 160,
  parameter int V_BLANK  = 8000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output state_t      state,
  output logic [10:0] col,
  output logic [10:0] row
);

  // One blank counter serves both blanking intervals since they never overlap.
  localparam int BMAX = (V_BLANK > H_BLANK) ? V_BLANK : H_BLANK;
  localparam int BW   = $clog2(BMAX + 1);

  localparam logic [BW-1:0] V_LAST   = BW'(V_BLANK - 1);
  localparam logic [BW-1:0] H_LAST   = BW'(H_BLANK - 1);
  localparam logic [10:0]   COL_LAST = 11'(H_ACTIVE - 1);
  localparam logic [10:0]   ROW_LAST = 11'(V_ACTIVE - 1);

  state_t         state_n;
  logic [BW-1:0]  cnt, cnt_n;
  logic [10:0]    col_n, row_n;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_VBLANK;
      cnt   <= '0;
      col   <= '0;
      row   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      col   <= col_n;
      row   <= row_n;
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    col_n   = col;
    row_n   = row;
    case (state)
      S_VBLANK: begin
        // Parks on the terminal count until a frame is allowed to start.
        if (cnt == V_LAST) begin
          if (enable) begin
            state_n = S_LINE;
            col_n   = '0;
            row_n   = '0;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_LINE: begin
        if (col == COL_LAST) begin
          cnt_n   = '0;
          state_n = (row == ROW_LAST) ? S_VBLANK : S_HBLANK;
        end else begin
          col_n = col + 11'd1;
        end
      end
      S_HBLANK: begin
        if (cnt == H_LAST) begin
          state_n = S_LINE;
          col_n   = '0;
          row_n   = row + 11'd1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = S_VBLANK;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: rtl/rgb_to_raw_bayer.sv
// Re-mosaics a handshaked RGB pixel stream into a 10-bit Bayer RAW stream with FVAL/LVAL timing.
// Timing comes from sensor_timing_gen; this level adds the handshake, channel select and output stage.
module rgb_to_raw_bayer
  import raw_bayer_pkg::*;
#(
  parameter int           H_ACTIVE    = 640,
  parameter int           V_ACTIVE    = 480,
  parameter int           H_BLANK     = 160,
  parameter int           V_BLANK     = 8000,
  parameter bayer_order_t BAYER_ORDER = BAYER_RGGB
) (
  input  logic        CCD_PIXCLK,
  input  logic        RST,
  input  logic        iEnable,
  input  logic [7:0]  iRed,
  input  logic [7:0]  iGreen,
  input  logic [7:0]  iBlue,
  input  logic        iValid,
  output logic        oReady,
  output logic [9:0]  mCCD_DATA,
  output logic        mCCD_FVAL,
  output logic        mCCD_LVAL,
  output logic [10:0] oX_Cont,
  output logic [10:0] oY_Cont,
  output logic        oFrame_Start,
  output logic        oUnderflow
);

  state_t      state;
  logic [10:0] col, row;
  logic        line;

  sensor_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .H_BLANK  (H_BLANK),
    .V_BLANK  (V_BLANK)
  ) u_timing (
    .clk    (CCD_PIXCLK),
    .rst    (RST),
    .enable (iEnable),
    .state  (state),
    .col    (col),
    .row    (row)
  );

  // Readiness depends only on the slot type, so a pixel is consumed every active cycle.
  assign line   = (state == S_LINE);
  assign oReady = line;

  // All stream outputs share one register stage so they stay mutually aligned.
  always_ff @(posedge CCD_PIXCLK) begin
    if (RST) begin
      mCCD_FVAL    <= 1'b0;
      mCCD_LVAL    <= 1'b0;
      mCCD_DATA    <= '0;
      oX_Cont      <= '0;
      oY_Cont      <= '0;
      oFrame_Start <= 1'b0;
      oUnderflow   <= 1'b0;
    end else begin
      mCCD_FVAL    <= (state != S_VBLANK);
      mCCD_LVAL    <= line;
      mCCD_DATA    <= (line && iValid) ? bayer_pick(BAYER_ORDER, col[0], row[0], iRed, iGreen, iBlue)
                                       : 10'd0;
      oX_Cont      <= col;
      oY_Cont      <= row;
      oFrame_Start <= (state != S_VBLANK) && !mCCD_FVAL;
      if (line && !iValid) oUnderflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rgb_to_raw_bayer.sv
// Self-checking bench: two orderings (RGGB and BGGR) run side by side against a slot-list frame model.
// Each frame is pre-expanded into a queue of blank/active slots; outputs follow one cycle later.
module tb_rgb_to_raw_bayer;
  import raw_bayer_pkg::*;

  localparam int HA = 4, VA = 2, HB = 2, VB = 3;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic        iEnable = 1'b0;
  logic [7:0]  iRed = '0, iGreen = '0, iBlue = '0;
  logic        iValid = 1'b0;

  logic        rdy0, fval0, lval0, fs0, uf0;
  logic [9:0]  data0;
  logic [10:0] x0, y0;
  logic        rdy3, fval3, lval3, fs3, uf3;
  logic [9:0]  data3;
  logic [10:0] x3, y3;

  rgb_to_raw_bayer #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .V_BLANK(VB),
                     .BAYER_ORDER(BAYER_RGGB)) dut (
    .CCD_PIXCLK(clk), .RST(RST), .iEnable(iEnable), .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
    .iValid(iValid), .oReady(rdy0), .mCCD_DATA(data0), .mCCD_FVAL(fval0), .mCCD_LVAL(lval0),
    .oX_Cont(x0), .oY_Cont(y0), .oFrame_Start(fs0), .oUnderflow(uf0));

  rgb_to_raw_bayer #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .V_BLANK(VB),
                     .BAYER_ORDER(BAYER_BGGR)) dut3 (
    .CCD_PIXCLK(clk), .RST(RST), .iEnable(iEnable), .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
    .iValid(iValid), .oReady(rdy3), .mCCD_DATA(data3), .mCCD_FVAL(fval3), .mCCD_LVAL(lval3),
    .oX_Cont(x3), .oY_Cont(y3), .oFrame_Start(fs3), .oUnderflow(uf3));

  always #5 clk = ~clk;

  typedef struct {
    bit fval;
    bit lval;
    bit term;
    int x;
    int y;
  } slot_t;

  slot_t q[$];
  int compared = 0, mismatched = 0;

  bit e_fval, e_lval, e_fs, e_uf;
  int e_d0, e_d3, e_x, e_y;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_sample(input int order, input int x, input int y,
                                    input int r, input int g, input int b);
    int rr, cc, c;
    rr = (y % 2) ^ (order / 2);
    cc = (x % 2) ^ (order % 2);
    if (rr == 0 && cc == 0) c = r;
    else if (rr == 1 && cc == 1) c = b;
    else c = g;
    return c * 4 + c / 64;
  endfunction

  task automatic build_frame();
    for (int i = 0; i < VB; i++) q.push_back('{0, 0, (i == VB - 1), 0, 0});
    for (int r = 0; r < VA; r++) begin
      for (int c = 0; c < HA; c++) q.push_back('{1, 1, 0, c, r});
      if (r < VA - 1) for (int i = 0; i < HB; i++) q.push_back('{1, 0, 0, 0, 0});
    end
  endtask

  task automatic model_reset();
    q.delete();
    build_frame();
    {e_fval, e_lval, e_fs, e_uf} = '0;
    e_d0 = 0; e_d3 = 0; e_x = 0; e_y = 0;
  endtask

  // mode 0: fixed pixel, always valid; 1: random pixel and valid; 2: fixed, valid low at row0/col2
  task automatic cycle(input bit en, input int mode);
    slot_t cur;
    cur = q[0];
    check("fval", fval0, e_fval);
    check("lval", lval0, e_lval);
    check("data_rggb", data0, e_d0);
    check("data_bggr", data3, e_d3);
    check("frame_start", fs0, e_fs);
    check("underflow", uf0, e_uf);
    check("fval_bggr", fval3, e_fval);
    if (e_lval) begin
      check("x_cont", x0, e_x);
      check("y_cont", y0, e_y);
      check("x_cont_bggr", x3, e_x);
      check("y_cont_bggr", y3, e_y);
    end
    check("ready", rdy0, cur.lval);

    iEnable = en;
    if (mode == 1) begin
      iRed = 8'($urandom); iGreen = 8'($urandom); iBlue = 8'($urandom);
      iValid = ($urandom_range(7) != 0);
    end else begin
      iRed = 8'hFF; iGreen = 8'h80; iBlue = 8'h01;
      iValid = !(mode == 2 && cur.lval && cur.x == 2 && cur.y == 0);
    end

    e_fs   = cur.fval && !e_fval;
    e_fval = cur.fval;
    e_lval = cur.lval;
    e_d0   = (cur.lval && iValid) ? ref_sample(0, cur.x, cur.y, iRed, iGreen, iBlue) : 0;
    e_d3   = (cur.lval && iValid) ? ref_sample(3, cur.x, cur.y, iRed, iGreen, iBlue) : 0;
    e_x    = cur.x;
    e_y    = cur.y;
    if (cur.lval && !iValid) e_uf = 1'b1;

    if (!(cur.term && !en)) begin
      void'(q.pop_front());
      if (q.size() == 0) build_frame();
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_fval", fval0, 0);
    check("rst_lval", lval0, 0);
    check("rst_data", data0, 0);
    check("rst_ready", rdy0, 0);
    check("rst_underflow", uf0, 0);
    check("rst_frame_start", fs0, 0);
    check("rst_data_bggr", data3, 0);
    RST = 1'b0;
    model_reset();
  endtask

  initial begin
    // Reset and first frame timing with a fixed pixel on both orderings.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1, 0);
    check("fval_low_before_rise", fval0, 0);
    cycle(1, 0);
    check("fval_rise_after_4", fval0, 1);
    check("frame_start_pulse", fs0, 1);
    for (int i = 0; i < 22; i++) cycle(1, 0);

    // Underflow on row 0 column 2, sticky until the next reset.
    do_reset();
    for (int i = 0; i < 16; i++) cycle(1, 2);
    check("underflow_sticky", uf0, 1);

    // Enable dropped during row 0: frame completes, next frame withheld.
    for (int i = 0; i < 40 && !(q[0].lval && q[0].y == 0); i++) cycle(1, 0);
    for (int i = 0; i < 30; i++) cycle(0, 0);
    check("withheld_fval", fval0, 0);
    check("withheld_ready", rdy0, 0);
    for (int i = 0; i < 14; i++) cycle(1, 0);

    // Reset in the middle of an active line.
    for (int i = 0; i < 40 && !(q[0].lval && q[0].x == 1); i++) cycle(1, 1);
    check("mid_line_ready", rdy0, 1);
    do_reset();
    for (int i = 0; i < 27; i++) cycle(1, 0);

    // Randomized pixels and valid gaps over several frames.
    for (int i = 0; i < 80; i++) cycle(1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
